// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg -- shared types and constants for the FFT twiddle datapath.
//   TW_W     default ROM magnitude width (twiddle components are TW_W+1 signed)
//   ANGLE_W  width of the first-quadrant ROM angle (0..90 degrees)
//   DEG_W    width of a whole-circle angle in degrees (0..359)
//   quadrant_t  which quarter of the circle an angle falls in
//   twiddle_t   one complex twiddle {re, im}
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int TW_W    = 16;
  localparam int ANGLE_W = 7;
  localparam int DEG_W   = 9;

  localparam logic [DEG_W-1:0] DEG_90  = 9'd90;
  localparam logic [DEG_W-1:0] DEG_180 = 9'd180;
  localparam logic [DEG_W-1:0] DEG_270 = 9'd270;
  localparam logic [DEG_W-1:0] DEG_360 = 9'd360;

  typedef enum logic [1:0] {
    Q0,  // 0..90
    Q1,  // 91..180
    Q2,  // 181..270
    Q3   // 271..359
  } quadrant_t;

  typedef struct packed {
    logic signed [TW_W:0] re;
    logic signed [TW_W:0] im;
  } twiddle_t;

endpackage

// File: rtl/twiddle_fold.sv
// ---------------------------------------------------------------------------
// twiddle_fold -- combinational quadrant fold of a whole-circle angle.
// Maps deg (0..359) onto the first-quadrant angle the quarter-wave ROM
// understands, plus the signs to apply to the ROM's sin and cos magnitudes.
// The quadrant boundaries 90/180/270 belong to the lower quadrant.
// Ports:
//   deg    in   DEG_W    angle in degrees, 0..359
//   angle  out  ANGLE_W  folded angle, 0..90
//   sneg   out  1        sin(deg) is negative
//   cneg   out  1        cos(deg) is negative
// ---------------------------------------------------------------------------
module twiddle_fold
  import fft_pkg::*;
(
  input  logic [DEG_W-1:0]   deg,
  output logic [ANGLE_W-1:0] angle,
  output logic               sneg,
  output logic               cneg
);

  quadrant_t        quad;
  logic [DEG_W-1:0] a_full;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    quad   = Q0;
    a_full = deg;
    sneg   = 1'b0;
    cneg   = 1'b0;

    if (deg <= DEG_90)       quad = Q0;
    else if (deg <= DEG_180) quad = Q1;
    else if (deg <= DEG_270) quad = Q2;
    else                     quad = Q3;

    case (quad)
      Q0: a_full = deg;
      Q1: begin
        a_full = DEG_180 - deg;
        cneg   = 1'b1;
      end
      Q2: begin
        a_full = deg - DEG_180;
        sneg   = 1'b1;
        cneg   = 1'b1;
      end
      Q3: begin
        a_full = DEG_360 - deg;
        sneg   = 1'b1;
      end
      default: a_full = deg;
    endcase
  end

  // Folded result is always 0..90, so the top bits are zero.
  assign angle = ANGLE_W'(a_full);

endmodule

// File: rtl/twiddle_gen.sv
// ---------------------------------------------------------------------------
// twiddle_gen -- twiddle factor generator W_N^k = cos(theta) - j*sin(theta),
// theta = 360*k/N degrees rounded to 1 degree, N = 2^LOG2N.
// Three-stage valid/ready pipeline around an external quarter-wave ROM:
//   S1 index -> degrees, S2 quadrant fold -> rom_angle, S3 sign the ROM data.
// All stages advance together when the output is empty or being taken.
// Optional build macro TWIDDLE_INVERSE_EN adds in_inv: when set for a
// request the imaginary part is +sin(theta) (inverse-FFT twiddle).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  index request handshake
//   in_k               twiddle index 0..N-1
//   in_inv             (TWIDDLE_INVERSE_EN only) request inverse twiddle
//   rom_angle          registered 0..90 angle to the ROM
//   rom_sin, rom_cos   unsigned ROM magnitudes for rom_angle
//   out_valid/ready    twiddle handshake
//   out_re, out_im     signed W+1-bit twiddle components
// ---------------------------------------------------------------------------
module twiddle_gen
  import fft_pkg::*;
#(
  parameter int W     = TW_W,
  parameter int LOG2N = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LOG2N-1:0]    in_k,
`ifdef TWIDDLE_INVERSE_EN
  input  logic                in_inv,
`endif
  output logic [ANGLE_W-1:0]  rom_angle,
  input  logic [W-1:0]        rom_sin,
  input  logic [W-1:0]        rom_cos,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W:0]   out_re,
  output logic signed [W:0]   out_im
);

  localparam int PW = LOG2N + 9;
  localparam logic [PW-1:0] HALF = PW'(1) << (LOG2N - 1);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic inv_s0;
`ifdef TWIDDLE_INVERSE_EN
  assign inv_s0 = in_inv;
`else
  assign inv_s0 = 1'b0;
`endif

  // S1: round 360*k/N to the nearest degree; a round-up to 360 is angle 0.
  logic [PW-1:0]    prod;
  logic [DEG_W-1:0] deg_raw;
  logic [DEG_W-1:0] deg_s0;
  assign prod    = PW'(in_k) * PW'(DEG_360) + HALF;
  assign deg_raw = DEG_W'(prod >> LOG2N);
  assign deg_s0  = (deg_raw == DEG_360) ? '0 : deg_raw;

  logic             v1;
  logic             inv1;
  logic [DEG_W-1:0] deg1;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's value from before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      inv1 <= 1'b0;
      deg1 <= '0;
    end else if (adv) begin
      v1   <= in_valid;
      inv1 <= inv_s0;
      deg1 <= deg_s0;
    end
  end

  // S2: fold into the first quadrant. The inverse request flips the sign
  // of the imaginary part, so it is merged into the sin sign here.
  logic [ANGLE_W-1:0] fold_angle;
  logic               fold_sneg;
  logic               fold_cneg;
  logic               v2;
  logic               sneg2;
  logic               cneg2;

  twiddle_fold u_fold (
    .deg   (deg1),
    .angle (fold_angle),
    .sneg  (fold_sneg),
    .cneg  (fold_cneg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      rom_angle <= '0;
      sneg2     <= 1'b0;
      cneg2     <= 1'b0;
    end else if (adv) begin
      v2        <= v1;
      rom_angle <= fold_angle;
      sneg2     <= fold_sneg ^ inv1;
      cneg2     <= fold_cneg;
    end
  end

  // S3: im = -sin(theta), so a negative sine produces a positive im.
  logic [W:0] cos_ext;
  logic [W:0] sin_ext;
  assign cos_ext = {1'b0, rom_cos};
  assign sin_ext = {1'b0, rom_sin};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out_re    <= cneg2 ? -cos_ext : cos_ext;
      out_im    <= sneg2 ? sin_ext : -sin_ext;
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// ---------------------------------------------------------------------------
// tb_twiddle_gen -- directed bench for twiddle_gen (W=16, LOG2N=10).
// The ROM model is synthetic so sin and cos are distinguishable:
//   sin_rom[a] = 700*a, cos_rom[a] = 65535 - 500*a
// e.g. a=90: sin 63000, cos 20535; a=45: sin 31500, cos 43035.
// ---------------------------------------------------------------------------
module tb_twiddle_gen;
  import fft_pkg::*;

  localparam int W     = 16;
  localparam int LOG2N = 10;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [LOG2N-1:0]    in_k;
`ifdef TWIDDLE_INVERSE_EN
  logic                in_inv;
`endif
  logic [ANGLE_W-1:0]  rom_angle;
  logic [W-1:0]        rom_sin;
  logic [W-1:0]        rom_cos;
  logic                out_valid;
  logic                out_ready;
  logic signed [W:0]   out_re;
  logic signed [W:0]   out_im;

  twiddle_gen #(.W(W), .LOG2N(LOG2N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_k      (in_k),
`ifdef TWIDDLE_INVERSE_EN
    .in_inv    (in_inv),
`endif
    .rom_angle (rom_angle),
    .rom_sin   (rom_sin),
    .rom_cos   (rom_cos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  assign rom_sin = W'(32'(rom_angle) * 700);
  assign rom_cos = W'(65535 - 32'(rom_angle) * 500);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated request with out_ready high: rom_angle is checked two
  // cycles after accept and the twiddle three cycles after accept.
  task automatic run_one(input string tag, input int k, input int exp_angle,
                         input int exp_re, input int exp_im);
    @(negedge clk);
    in_valid  = 1'b1;
    in_k      = LOG2N'(k);
    out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "_valid_c1"}, out_valid, 0);
    @(negedge clk);
    #1 check({tag, "_angle"}, rom_angle, exp_angle);
    check({tag, "_valid_c2"}, out_valid, 0);
    @(negedge clk);
    #1 check({tag, "_valid_c3"}, out_valid, 1);
    check({tag, "_re"}, out_re, exp_re);
    check({tag, "_im"}, out_im, exp_im);
  endtask

  // Expected folded angles for k = 0..15 at N = 1024, all in quadrant 0.
  int burst_angle [16] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 4, 4, 4, 5, 5, 5};

  initial begin
    twiddle_t snap;
    logic [ANGLE_W-1:0] snap_angle;
    logic have_snap;
    int sent;
    int got;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_k      = '0;
    out_ready = 1'b1;
`ifdef TWIDDLE_INVERSE_EN
    in_inv    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_rom_angle", rom_angle, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed single requests across all quadrants and boundaries.
    run_one("k0",    0,    0,  65535,      0);
    run_one("k128",  128,  45,  43035, -31500);
    run_one("k256",  256,  90,  20535, -63000);
    run_one("k258",  258,  89, -21035, -62300);
    run_one("k384",  384,  45, -43035, -31500);
    run_one("k512",  512,  0,  -65535,      0);
    run_one("k640",  640,  45, -43035,  31500);
    run_one("k768",  768,  90, -20535,  63000);
    run_one("k896",  896,  45,  43035,  31500);
    run_one("k1022", 1022, 1,   65035,    700);
    run_one("k1023", 1023, 0,   65535,      0);

    // Same k=256 request with the inverse flag where the port exists.
`ifdef TWIDDLE_INVERSE_EN
    in_inv = 1'b1;
    run_one("k256_inv", 256, 90, 20535, 63000);
    in_inv = 1'b0;
`else
    run_one("k256_fwd", 256, 90, 20535, -63000);
`endif

    // Back-to-back k = 0..15 with the consumer stalling in cycles 4..7.
    sent      = 0;
    got       = 0;
    have_snap = 1'b0;
    snap      = '0;
    snap_angle = '0;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (sent < 16);
      in_k      = LOG2N'(sent);
      #1;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        if (have_snap) begin
          check("stall_hold_re", out_re, snap.re);
          check("stall_hold_im", out_im, snap.im);
          check("stall_hold_angle", rom_angle, snap_angle);
        end else begin
          snap.re    = out_re;
          snap.im    = out_im;
          snap_angle = rom_angle;
          have_snap  = 1'b1;
        end
      end else begin
        have_snap = 1'b0;
      end
      if (out_valid && out_ready) begin
        check($sformatf("burst_re_%0d", got), out_re,
              65535 - 500 * burst_angle[got]);
        check($sformatf("burst_im_%0d", got), out_im,
              -700 * burst_angle[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("burst_count", got, 16);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("burst_no_extra", out_valid, 0);
    end

    // Reset with two requests in flight: nothing may survive it.
    @(negedge clk);
    in_valid = 1'b1;
    in_k     = LOG2N'(128);
    @(negedge clk);
    in_k     = LOG2N'(384);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_re", out_re, 0);
    check("mid_rst_out_im", out_im, 0);
    check("mid_rst_angle", rom_angle, 0);
    check("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("mid_rst_no_stale", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
